vram_arbiter: RTL

- Shares the single video_memory access port between two requesters: the display fetch path (scanline pixel reads, hard deadline) and the drawing engine (instruction-driven reads and writes).
- Sits between graphics_mode_module and video_memory on the pixel clock.
- Gives display fetch absolute priority, buffers engine writes in a small queue, and sequences engine reads so no read overtakes a queued write.

---
 rtl/vram_arbiter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/vram_arbiter.sv
// Single-port video memory arbiter: display fetch has absolute priority, engine
// writes are buffered in a small FIFO, engine reads wait for the FIFO to empty.
module vram_arbiter #(
    parameter int ADDR_W   = 17,
    parameter int DATA_W   = 8,
    parameter int WQ_DEPTH = 4,
    parameter int RD_LAT   = 1
) (
    input  logic                        video_clk,
    input  logic                        reset_n,
    input  logic                        disp_req,
    input  logic [ADDR_W-1:0]           disp_addr,
    output logic [DATA_W-1:0]           disp_data,
    output logic                        disp_valid,
    input  logic                        eng_req,
    input  logic                        eng_we,
    input  logic [ADDR_W-1:0]           eng_addr,
    input  logic [DATA_W-1:0]           eng_wdata,
    output logic                        eng_ack,
    output logic [DATA_W-1:0]           eng_rdata,
    output logic                        eng_rvalid,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_din,
    output logic                        mem_we,
    input  logic [DATA_W-1:0]           mem_dout,
    output logic [$clog2(WQ_DEPTH):0]   wq_level,
    output logic                        busy
);

    localparam int   PTR_W    = $clog2(WQ_DEPTH);
    localparam int   LVL_W    = PTR_W + 1;
    localparam logic OWN_DISP = 1'b0;
    localparam logic OWN_ENG  = 1'b1;

    typedef enum logic {ENG_IDLE, ENG_RD_WAIT} eng_state_t;

    eng_state_t state_reg, state_next;

    logic [ADDR_W-1:0] wq_addr_mem [WQ_DEPTH];
    logic [DATA_W-1:0] wq_data_mem [WQ_DEPTH];
    logic [PTR_W-1:0]  head_reg, tail_reg;
    logic [LVL_W-1:0]  level_reg, level_next;
    logic              busy_reg, busy_next;

    logic [ADDR_W-1:0] mem_addr_reg, mem_addr_next;
    logic [DATA_W-1:0] mem_din_reg, mem_din_next;
    logic              mem_we_reg, mem_we_next;

    // One {valid, owner} tag per pipeline stage between decision and mem_dout.
    logic [RD_LAT:0]   tag_valid_reg, tag_owner_reg;
    logic              issue_valid, issue_owner;

    logic wq_empty, wq_full, wr_ack, rd_ack, pop, rd_done;

    assign wq_empty = (level_reg == '0);
    assign wq_full  = (level_reg == LVL_W'(WQ_DEPTH));
    assign wr_ack   = eng_req & eng_we & ~wq_full;
    assign rd_ack   = (state_reg == ENG_IDLE) & eng_req & ~eng_we & wq_empty & ~disp_req;
    assign eng_ack  = wr_ack | rd_ack;
    assign rd_done  = tag_valid_reg[RD_LAT] & (tag_owner_reg[RD_LAT] == OWN_ENG);

    // Slot arbitration: display, then engine read, then queue drain.
    always_comb begin
        mem_addr_next = mem_addr_reg;
        mem_din_next  = mem_din_reg;
        mem_we_next   = 1'b0;
        issue_valid   = 1'b0;
        issue_owner   = OWN_DISP;
        pop           = 1'b0;
        if (disp_req) begin
            mem_addr_next = disp_addr;
            issue_valid   = 1'b1;
        end else if (rd_ack) begin
            mem_addr_next = eng_addr;
            issue_valid   = 1'b1;
            issue_owner   = OWN_ENG;
        end else if (!wq_empty) begin
            mem_addr_next = wq_addr_mem[head_reg];
            mem_din_next  = wq_data_mem[head_reg];
            mem_we_next   = 1'b1;
            pop           = 1'b1;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ENG_IDLE:    if (rd_ack)  state_next = ENG_RD_WAIT;
            ENG_RD_WAIT: if (rd_done) state_next = ENG_IDLE;
            default:     state_next = ENG_IDLE;
        endcase
    end

    always_comb begin
        level_next = level_reg;
        case ({wr_ack, pop})
            2'b10:   level_next = level_reg + LVL_W'(1);
            2'b01:   level_next = level_reg - LVL_W'(1);
            default: level_next = level_reg;
        endcase
        busy_next = (level_next != '0) | (state_next == ENG_RD_WAIT);
    end

    always_ff @(posedge video_clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg     <= ENG_IDLE;
            head_reg      <= '0;
            tail_reg      <= '0;
            level_reg     <= '0;
            busy_reg      <= 1'b0;
            mem_addr_reg  <= '0;
            mem_din_reg   <= '0;
            mem_we_reg    <= 1'b0;
            tag_valid_reg <= '0;
            tag_owner_reg <= '0;
        end else begin
            state_reg     <= state_next;
            level_reg     <= level_next;
            busy_reg      <= busy_next;
            mem_addr_reg  <= mem_addr_next;
            mem_din_reg   <= mem_din_next;
            mem_we_reg    <= mem_we_next;
            tag_valid_reg <= {tag_valid_reg[RD_LAT-1:0], issue_valid};
            tag_owner_reg <= {tag_owner_reg[RD_LAT-1:0], issue_owner};
            if (wr_ack) tail_reg <= tail_reg + PTR_W'(1);
            if (pop)    head_reg <= head_reg + PTR_W'(1);
        end
    end

    // Queue storage needs no reset: only entries between head and tail are read.
    always_ff @(posedge video_clk) begin
        if (wr_ack) begin
            wq_addr_mem[tail_reg] <= eng_addr;
            wq_data_mem[tail_reg] <= eng_wdata;
        end
    end

    assign disp_valid = tag_valid_reg[RD_LAT] & (tag_owner_reg[RD_LAT] == OWN_DISP);
    assign eng_rvalid = rd_done;
    assign disp_data  = disp_valid ? mem_dout : '0;
    assign eng_rdata  = eng_rvalid ? mem_dout : '0;
    assign mem_addr   = mem_addr_reg;
    assign mem_din    = mem_din_reg;
    assign mem_we     = mem_we_reg;
    assign wq_level   = level_reg;
    assign busy       = busy_reg;

endmodule
